// File: rtl/jpeg_bit_unstuffer.sv
// JPEG entropy-segment bit unstuffer: strips 0xFF00 stuffing, holds markers, and
// offers an MSB-first peek/consume bit window. Optional macro: JPEG_UNSTUFF_STATS_EN.
module jpeg_bit_unstuffer #(
  parameter int unsigned PEEK_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  output logic                              in_ready,
  output logic [PEEK_W-1:0]                 peek_data,
  output logic [$clog2(2*PEEK_W+1)-1:0]     avail,
  input  logic                              cons_valid,
  input  logic [$clog2(PEEK_W+1)-1:0]       cons_len,
  output logic                              marker_valid,
  output logic [7:0]                        marker_code,
  input  logic                              marker_ack,
  output logic                              err_underflow
`ifdef JPEG_UNSTUFF_STATS_EN
  ,
  output logic [15:0]                       stuff_cnt
`endif
);

  localparam int unsigned BUF_W   = 2 * PEEK_W;
  localparam int unsigned AVAIL_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    DATA        = 2'd0,
    FF_SEEN     = 2'd1,
    MARKER_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   bits_q, bits_d;
  logic [AVAIL_W-1:0] avail_q, avail_d;
  logic [7:0]         code_q, code_d;
  logic               err_q, err_d;

  logic               accept;
  logic               over;
  logic               append;
  logic               drop_ff;
  logic [AVAIL_W-1:0] consumed;
  logic [AVAIL_W-1:0] rem;
  logic [BUF_W-1:0]   shifted;

  assign in_ready      = (state_q != MARKER_HOLD) && (avail_q <= AVAIL_W'(BUF_W - 8));
  assign peek_data     = bits_q[BUF_W-1 -: PEEK_W];
  assign avail         = avail_q;
  assign marker_valid  = (state_q == MARKER_HOLD);
  assign marker_code   = code_q;
  assign err_underflow = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DATA;
      bits_q  <= '0;
      avail_q <= '0;
      code_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      avail_q <= avail_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // Consume from the head first; an appended byte lands behind what remains.
  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    avail_d  = avail_q;
    code_d   = code_q;
    err_d    = err_q;
    append   = 1'b0;
    drop_ff  = 1'b0;

    accept   = in_valid && in_ready;
    over     = cons_valid && (AVAIL_W'(cons_len) > avail_q);
    consumed = !cons_valid ? '0 : (over ? avail_q : AVAIL_W'(cons_len));
    rem      = avail_q - consumed;
    shifted  = bits_q << consumed;

    case (state_q)
      DATA: begin
        if (accept) begin
          append = 1'b1;
          if (in_data == 8'hFF) state_d = FF_SEEN;
        end
      end
      FF_SEEN: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            state_d = DATA;
          end else begin
            drop_ff = 1'b1;
            code_d  = in_data;
            state_d = MARKER_HOLD;
          end
        end
      end
      MARKER_HOLD: begin
        if (marker_ack) state_d = DATA;
      end
      default: state_d = DATA;
    endcase

    if (append) begin
      avail_d = rem + AVAIL_W'(8);
      bits_d  = shifted | ({in_data, {(BUF_W-8){1'b0}}} >> rem);
    end else if (drop_ff) begin
      // The 0xFF sits at the tail; a same-cycle consume may already have eaten part of it.
      avail_d = (rem >= AVAIL_W'(8)) ? (rem - AVAIL_W'(8)) : '0;
      bits_d  = shifted & ~({BUF_W{1'b1}} >> avail_d);
    end else begin
      avail_d = rem;
      bits_d  = shifted;
    end

    err_d = err_q | over;
  end

`ifdef JPEG_UNSTUFF_STATS_EN
  logic stuff_hit;
  assign stuff_hit = (state_q == FF_SEEN) && accept && (in_data == 8'h00);

  // Saturating count of dropped 0x00 stuffing bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuff_cnt <= 16'h0000;
    end else if (stuff_hit && (stuff_cnt != 16'hFFFF)) begin
      stuff_cnt <= stuff_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_bit_unstuffer.sv
// Directed table-driven bench for jpeg_bit_unstuffer (PEEK_W = 16), plus
// hand-written underflow and reset-during-marker sequences.
module tb_jpeg_bit_unstuffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] peek_data;
  logic [5:0]  avail;
  logic        cons_valid;
  logic [4:0]  cons_len;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        err_underflow;
`ifdef JPEG_UNSTUFF_STATS_EN
  logic [15:0] stuff_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  jpeg_bit_unstuffer #(.PEEK_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .peek_data     (peek_data),
    .avail         (avail),
    .cons_valid    (cons_valid),
    .cons_len      (cons_len),
    .marker_valid  (marker_valid),
    .marker_code   (marker_code),
    .marker_ack    (marker_ack),
    .err_underflow (err_underflow)
`ifdef JPEG_UNSTUFF_STATS_EN
    ,
    .stuff_cnt     (stuff_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        vc;
    logic [4:0]  len;
    logic        ack;
    logic [5:0]  e_avail;
    logic [15:0] e_peek;
    logic        e_mv;
    logic        e_rdy;
    logic [7:0]  e_code;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vin, logic [7:0] din, logic vc, logic [4:0] len, logic ack,
                              logic [5:0] ea, logic [15:0] ep, logic emv, logic erdy,
                              logic [7:0] ecode, logic eerr);
    vec_t v;
    v.vin = vin; v.din = din; v.vc = vc; v.len = len; v.ack = ack;
    v.e_avail = ea; v.e_peek = ep; v.e_mv = emv; v.e_rdy = erdy;
    v.e_code = ecode; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic drive(input logic vin, input logic [7:0] din, input logic vc,
                       input logic [4:0] len, input logic ack);
    in_valid = vin; in_data = din; cons_valid = vc; cons_len = len; marker_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00; cons_valid = 1'b0; cons_len = '0; marker_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; cons_valid = 1'b0; cons_len = '0; marker_ack = 1'b0;

    //          vin din    vc len ack  avail peek     mv rdy code   err
    vecs.push_back(mk(0, 8'h00, 0, 0,  0,  0, 16'h0000, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'hA5, 0, 0,  0,  8, 16'hA500, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0, 16, 16'hA53C, 0, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 1, 16, 0,  0, 16'h0000, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  0,  8, 16'hFF00, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0,  0,  8, 16'hFF00, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'h12, 0, 0,  0, 16, 16'hFF12, 0, 1, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 1, 16, 0,  0, 16'h0000, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'h81, 0, 0,  0,  8, 16'h8100, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'hFF, 0, 0,  0, 16, 16'h81FF, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 8'hD9, 0, 0,  0,  8, 16'h8100, 1, 0, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h77, 0, 0,  0,  8, 16'h8100, 1, 0, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0,  1,  8, 16'h8100, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 8,  0,  0, 16'h0000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 0,  0,  8, 16'hF000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 16, 16'hF000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h5A, 1, 4,  0, 20, 16'h0005, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 16, 0,  4, 16'hA000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h11, 0, 0,  0, 12, 16'hA110, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h22, 0, 0,  0, 20, 16'hA112, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0,  0, 28, 16'hA112, 0, 0, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h44, 0, 0,  0, 28, 16'hA112, 0, 0, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 8,  0, 20, 16'h1223, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 16, 0,  4, 16'h3000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4,  0,  0, 16'h0000, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(1, 8'h9C, 0, 0,  0,  8, 16'h9C00, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  0,  8, 16'h9C00, 0, 1, 8'hD9, 0));
    vecs.push_back(mk(0, 8'h00, 1, 8,  0,  0, 16'h0000, 0, 1, 8'hD9, 0));

    #1;
    chk("rst_avail", -1, 32'(avail), 32'd0);
    chk("rst_peek", -1, 32'(peek_data), 32'h0);
    chk("rst_marker_valid", -1, 32'(marker_valid), 32'd0);
    chk("rst_err", -1, 32'(err_underflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vin, vecs[i].din, vecs[i].vc, vecs[i].len, vecs[i].ack);
      chk("avail", i, 32'(avail), 32'(vecs[i].e_avail));
      chk("peek_data", i, 32'(peek_data), 32'(vecs[i].e_peek));
      chk("marker_valid", i, 32'(marker_valid), 32'(vecs[i].e_mv));
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
      chk("marker_code", i, 32'(marker_code), 32'(vecs[i].e_code));
      chk("err_underflow", i, 32'(err_underflow), 32'(vecs[i].e_err));
      idle_inputs();
    end
`ifdef JPEG_UNSTUFF_STATS_EN
    chk("stuff_cnt", 100, 32'(stuff_cnt), 32'd1);
`endif

    // Over-consume: avail 3, request 5 -> empty buffer, sticky error.
    drive(1, 8'hE0, 0, 0, 0); idle_inputs();
    drive(0, 8'h00, 1, 5, 0);
    chk("uf_avail3", 200, 32'(avail), 32'd3);
    chk("uf_err_before", 200, 32'(err_underflow), 32'd0);
    idle_inputs();
    drive(0, 8'h00, 1, 5, 0);
    chk("uf_avail0", 201, 32'(avail), 32'd0);
    chk("uf_err_set", 201, 32'(err_underflow), 32'd1);
    idle_inputs();
    drive(1, 8'h55, 0, 0, 0);
    chk("uf_refill_avail", 202, 32'(avail), 32'd8);
    chk("uf_refill_peek", 202, 32'(peek_data), 32'h5500);
    chk("uf_err_sticky", 202, 32'(err_underflow), 32'd1);
    idle_inputs();
    drive(0, 8'h00, 1, 8, 0);
    chk("uf_err_sticky2", 203, 32'(err_underflow), 32'd1);
    idle_inputs();

    // Enter MARKER_HOLD with buffered data, then reset asynchronously.
    drive(1, 8'h01, 0, 0, 0); idle_inputs();
    drive(1, 8'h02, 0, 0, 0); idle_inputs();
    drive(1, 8'hFF, 0, 0, 0); idle_inputs();
    drive(1, 8'hC0, 0, 0, 0);
    chk("hold_mv", 300, 32'(marker_valid), 32'd1);
    chk("hold_avail", 300, 32'(avail), 32'd16);
    chk("hold_peek", 300, 32'(peek_data), 32'h0102);
    chk("hold_code", 300, 32'(marker_code), 32'hC0);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_avail", 301, 32'(avail), 32'd0);
    chk("arst_mv", 301, 32'(marker_valid), 32'd0);
    chk("arst_peek", 301, 32'(peek_data), 32'h0);
    chk("arst_code", 301, 32'(marker_code), 32'h00);
    chk("arst_err", 301, 32'(err_underflow), 32'd0);
`ifdef JPEG_UNSTUFF_STATS_EN
    chk("arst_stuff_cnt", 301, 32'(stuff_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 302, 32'(in_ready), 32'd1);
    idle_inputs();
    drive(1, 8'h00, 0, 0, 0);
    chk("post_rst_00_avail", 303, 32'(avail), 32'd8);
    chk("post_rst_00_peek", 303, 32'(peek_data), 32'h0000);
    idle_inputs();
    drive(1, 8'h00, 0, 0, 0);
    chk("post_rst_00b_avail", 304, 32'(avail), 32'd16);
    chk("post_rst_mv", 304, 32'(marker_valid), 32'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
